fetch_stage: RTL and testbench

Instruction-fetch stage of the 5-stage RV32I pipeline, directly upstream of decode. It generates the fetch PC and issues in-order requests to instruction memory over a valid/ready interface. Responses are buffered in a small prefetch FIFO, and the stage drives the IF/ID pipeline register (instrD, PCD, PCplus4D). It also handles decode stalls and taken-branch/jump redirects from execute.

---
 rtl/fetch_stage_if.sv | 25 ++
 rtl/fetch_stage.sv | 159 +++++++++++++++
 tb/tb_fetch_stage.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Instruction-memory channel between the fetch stage (master) and instruction memory (slave).
// Requests use valid/ready; responses return in order with a single valid strobe.
interface fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: PC generation, credit-limited imem requests,
// in-order prefetch FIFO, and the IF/ID pipeline register with stall and redirect handling.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h00000000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  fetch_stage_if.master        imem,
  input  logic                 stallD,
  input  logic                 redirect_valid,
  input  logic [31:0]          redirect_pc,
  output logic [31:0]          instrD,
  output logic [31:0]          PCD,
  output logic [31:0]          PCplus4D,
  output logic                 validD
);

  localparam int          PTR_W = $clog2(FIFO_DEPTH);
  localparam int          CNT_W = PTR_W + 1;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic [31:0]      pcQ, pcD;
  logic [31:0]      rspPcQ, rspPcD;
  logic [CNT_W-1:0] outQ, outD;
  logic [CNT_W-1:0] discQ, discD;
  logic [CNT_W-1:0] cntQ, cntD;
  logic [PTR_W-1:0] rdPtrQ, rdPtrD;
  logic [PTR_W-1:0] wrPtrQ, wrPtrD;

  logic [31:0]      fifoPc   [FIFO_DEPTH];
  logic [31:0]      fifoData [FIFO_DEPTH];

  logic [31:0]      ifInstrQ, ifInstrD;
  logic [31:0]      ifPcQ, ifPcD;
  logic [31:0]      ifPc4Q, ifPc4D;
  logic             ifValidQ, ifValidD;

  logic [CNT_W:0]   credit;
  logic             reqValid;
  logic             accept;
  logic             push;
  logic             pop;
  logic [31:0]      redirTarget;
  logic             unusedRedirLsb;

  assign redirTarget    = {redirect_pc[31:2], 2'b00};
  assign unusedRedirLsb = ^redirect_pc[1:0];

  // Handshake decode: credit counts live in-flight requests plus buffered
  // responses, so the FIFO always has room for every response we can receive.
  always_comb begin
    credit   = {1'b0, outQ} + {1'b0, cntQ};
    reqValid = !rst && !redirect_valid && (discQ == '0) &&
               (credit < (CNT_W+1)'(FIFO_DEPTH));
    accept   = reqValid && imem.imem_ready;
    push     = imem.imem_rvalid && !redirect_valid && (discQ == '0);
    pop      = !redirect_valid && !stallD && (cntQ != '0);
  end

  // Fetch PC, response-PC tracking, counters and FIFO pointers.
  always_comb begin
    pcD    = pcQ;
    rspPcD = rspPcQ;
    outD   = outQ + CNT_W'(accept) - CNT_W'(push);
    discD  = discQ;
    cntD   = cntQ + CNT_W'(push) - CNT_W'(pop);
    rdPtrD = rdPtrQ;
    wrPtrD = wrPtrQ;

    if (accept) begin
      pcD = pcQ + 32'd4;
    end
    if (push) begin
      wrPtrD = wrPtrQ + 1'b1;
      rspPcD = rspPcQ + 32'd4;
    end
    if (pop) begin
      rdPtrD = rdPtrQ + 1'b1;
    end
    if (imem.imem_rvalid && (discQ != '0)) begin
      discD = discQ - 1'b1;
    end

    // Every request still in flight after this cycle's response belongs to the
    // old path; it becomes a discard and the response PC restarts at the target.
    if (redirect_valid) begin
      pcD    = redirTarget;
      rspPcD = redirTarget;
      outD   = '0;
      discD  = discQ + outQ - CNT_W'(imem.imem_rvalid);
      cntD   = '0;
      rdPtrD = '0;
      wrPtrD = '0;
    end
  end

  // IF/ID register next state: redirect bubble, stall hold, pop, or empty bubble.
  always_comb begin
    ifInstrD = ifInstrQ;
    ifPcD    = ifPcQ;
    ifPc4D   = ifPc4Q;
    ifValidD = ifValidQ;

    if (redirect_valid || (!stallD && (cntQ == '0))) begin
      ifInstrD = NOP;
      ifValidD = 1'b0;
    end else if (pop) begin
      ifInstrD = fifoData[rdPtrQ];
      ifPcD    = fifoPc[rdPtrQ];
      ifPc4D   = fifoPc[rdPtrQ] + 32'd4;
      ifValidD = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcQ      <= RESET_PC;
      rspPcQ   <= RESET_PC;
      outQ     <= '0;
      discQ    <= '0;
      cntQ     <= '0;
      rdPtrQ   <= '0;
      wrPtrQ   <= '0;
      ifInstrQ <= NOP;
      ifPcQ    <= '0;
      ifPc4Q   <= '0;
      ifValidQ <= 1'b0;
    end else begin
      pcQ      <= pcD;
      rspPcQ   <= rspPcD;
      outQ     <= outD;
      discQ    <= discD;
      cntQ     <= cntD;
      rdPtrQ   <= rdPtrD;
      wrPtrQ   <= wrPtrD;
      ifInstrQ <= ifInstrD;
      ifPcQ    <= ifPcD;
      ifPc4Q   <= ifPc4D;
      ifValidQ <= ifValidD;
    end
  end

  // FIFO storage needs no reset; occupancy is governed by the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      fifoPc[wrPtrQ]   <= rspPcQ;
      fifoData[wrPtrQ] <= imem.imem_rdata;
    end
  end

  assign imem.imem_req  = reqValid;
  assign imem.imem_addr = pcQ;
  assign instrD         = ifInstrQ;
  assign PCD            = ifPcQ;
  assign PCplus4D       = ifPc4Q;
  assign validD         = ifValidQ;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a queue-based memory and fetch model predicts
// imem_req/imem_addr and the IF/ID register every cycle under directed and random stimulus.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h00000000;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] NOP      = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallD;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] instrD;
  logic [31:0] PCD;
  logic [31:0] PCplus4D;
  logic        validD;

  fetch_stage_if imem();

  fetch_stage #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem           (imem),
    .stallD         (stallD),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instrD         (instrD),
    .PCD            (PCD),
    .PCplus4D       (PCplus4D),
    .validD         (validD)
  );

  always #5 clk = ~clk;

  int checkCount = 0;
  int failCount  = 0;
  int cycleCount = 0;
  int minLat     = 1;
  int maxLat     = 1;

  // Reference model: fetch PC, in-flight requests (oldest first), stale count, buffered PCs.
  logic [31:0] fetchPc;
  logic [31:0] memAddr[$];
  int          memDue[$];
  int          staleCnt;
  logic [31:0] bufPc[$];
  logic [31:0] expInstr, expPcD, expPc4D;
  logic        expValid;

  function automatic logic [31:0] wordFor(input logic [31:0] a);
    return a ^ 32'hC0DE0000;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    checkCount++;
    if (got !== want) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", tag, got, want, cycleCount);
    end
  endtask

  task automatic modelReset();
    fetchPc  = RESET_PC;
    memAddr.delete();
    memDue.delete();
    staleCnt = 0;
    bufPc.delete();
    expInstr = NOP;
    expPcD   = 32'h0;
    expPc4D  = 32'h0;
    expValid = 1'b0;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, ".imem_req"},  32'(imem.imem_req), 32'h0);
    checkOutput({tag, ".imem_addr"}, imem.imem_addr, RESET_PC);
    checkOutput({tag, ".instrD"},    instrD, NOP);
    checkOutput({tag, ".PCD"},       PCD, 32'h0);
    checkOutput({tag, ".PCplus4D"},  PCplus4D, 32'h0);
    checkOutput({tag, ".validD"},    32'(validD), 32'h0);
  endtask

  // One clock cycle: drive inputs at negedge, check the request side, advance the model at posedge, check IF/ID.
  task automatic applyStimulus(input logic stall, input logic redir, input logic [31:0] rpc, input int readyPct);
    logic        rv, rdy, expReq, acc;
    logic [31:0] headAddr, p;
    headAddr = 32'h0;
    @(negedge clk);
    cycleCount++;
    rv     = (memAddr.size() > 0) && (memDue[0] <= cycleCount);
    rdy    = ($urandom_range(99) < readyPct);
    expReq = !redir && (staleCnt == 0) && ((memAddr.size() + bufPc.size()) < DEPTH);
    stallD              = stall;
    redirect_valid      = redir;
    redirect_pc         = rpc;
    imem.imem_ready     = rdy;
    imem.imem_rvalid    = rv;
    imem.imem_rdata     = rv ? wordFor(memAddr[0]) : $urandom();
    #1;
    checkOutput("imem_req",  32'(imem.imem_req), 32'(expReq));
    checkOutput("imem_addr", imem.imem_addr, fetchPc);
    acc = expReq && rdy;
    @(posedge clk);
    if (rv) begin
      headAddr = memAddr.pop_front();
      void'(memDue.pop_front());
    end
    if (redir) begin
      expInstr = NOP;
      expValid = 1'b0;
      bufPc.delete();
    end else if (!stall) begin
      if (bufPc.size() > 0) begin
        p        = bufPc.pop_front();
        expInstr = wordFor(p);
        expPcD   = p;
        expPc4D  = p + 32'd4;
        expValid = 1'b1;
      end else begin
        expInstr = NOP;
        expValid = 1'b0;
      end
    end
    if (rv) begin
      if (staleCnt > 0) staleCnt--;
      else if (!redir) bufPc.push_back(headAddr);
    end
    if (redir) begin
      staleCnt = memAddr.size();
      fetchPc  = {rpc[31:2], 2'b00};
    end else if (acc) begin
      memAddr.push_back(fetchPc);
      memDue.push_back(cycleCount + int'($urandom_range(maxLat, minLat)));
      fetchPc = fetchPc + 32'd4;
    end
    #1;
    checkOutput("instrD",   instrD, expInstr);
    checkOutput("PCD",      PCD, expPcD);
    checkOutput("PCplus4D", PCplus4D, expPc4D);
    checkOutput("validD",   32'(validD), 32'(expValid));
  endtask

  task automatic waitValid(input string tag);
    int n = 0;
    do begin
      applyStimulus(1'b0, 1'b0, 32'h0, 100);
      n++;
    end while (!validD && n < 60);
    if (!validD) checkOutput({tag, ".timeout"}, 32'h0, 32'h1);
  endtask

  task automatic applyAsyncReset();
    @(negedge clk);
    #2;
    rst              = 1'b1;
    stallD           = 1'b0;
    redirect_valid   = 1'b0;
    imem.imem_ready  = 1'b0;
    imem.imem_rvalid = 1'b0;
    #1;
    checkResetState("asyncReset");
    modelReset();
    @(posedge clk);
    #4;
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] heldPc;
    int          n;
    rst              = 1'b1;
    stallD           = 1'b0;
    redirect_valid   = 1'b0;
    redirect_pc      = 32'h0;
    imem.imem_ready  = 1'b0;
    imem.imem_rvalid = 1'b0;
    imem.imem_rdata  = 32'h0;
    modelReset();
    #2;
    checkResetState("por");
    @(posedge clk);
    @(posedge clk);
    #4;
    rst = 1'b0;

    // Streaming with 1-cycle memory: first instruction lands on the 3rd edge after release.
    minLat = 1; maxLat = 1;
    for (int i = 1; i <= 12; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 100);
      if (i <= 3) checkOutput("firstValidTiming", 32'(validD), (i == 3) ? 32'h1 : 32'h0);
      if (i == 3) checkOutput("firstPcD", PCD, RESET_PC);
    end

    // Five-cycle decode stall.
    heldPc = PCD;
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 32'h0, 100);
    checkOutput("stallHoldPc", PCD, heldPc);
    checkOutput("stallReqDrop", 32'(imem.imem_req), 32'h0);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 32'h0, 100);

    // Redirect with two requests in flight on a 3-cycle memory.
    minLat = 3; maxLat = 3;
    n = 0;
    while (memAddr.size() != 2 && n < 30) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 100);
      n++;
    end
    checkOutput("inflightBeforeRedirect", 32'(memAddr.size()), 32'd2);
    applyStimulus(1'b0, 1'b1, 32'h00000103, 100);
    checkOutput("redirBubble", 32'(validD), 32'h0);
    checkOutput("redirAddr", imem.imem_addr, 32'h00000100);
    waitValid("redirFirst");
    checkOutput("redirFirstPc", PCD, 32'h00000100);

    // Redirect and stall in the same cycle.
    minLat = 1; maxLat = 1;
    waitValid("preStallRedir");
    applyStimulus(1'b1, 1'b1, 32'h00000200, 100);
    checkOutput("stallRedirValid", 32'(validD), 32'h0);
    checkOutput("stallRedirInstr", instrD, NOP);

    // Redirect in the same cycle as a response.
    minLat = 2; maxLat = 2;
    n = 0;
    while (!(memAddr.size() > 0 && memDue[0] <= cycleCount + 1) && n < 30) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 100);
      n++;
    end
    applyStimulus(1'b0, 1'b1, 32'h00000300, 100);
    waitValid("rspRedir");
    checkOutput("rspRedirPc", PCD, 32'h00000300);

    // Address wrap at the top of the address space.
    minLat = 1; maxLat = 1;
    applyStimulus(1'b0, 1'b1, 32'hFFFFFFF8, 100);
    waitValid("wrap0");
    checkOutput("wrapPc0", PCD, 32'hFFFFFFF8);
    waitValid("wrap1");
    checkOutput("wrapPc1", PCD, 32'hFFFFFFFC);
    checkOutput("wrapPc4", PCplus4D, 32'h00000000);
    waitValid("wrap2");
    checkOutput("wrapPc2", PCD, 32'h00000000);

    // Asynchronous reset in the middle of a stream.
    minLat = 2; maxLat = 2;
    applyStimulus(1'b0, 1'b1, 32'h00000400, 100);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 32'h0, 100);
    applyAsyncReset();
    waitValid("postReset");
    checkOutput("postResetPc", PCD, RESET_PC);

    // Randomized traffic.
    minLat = 1; maxLat = 4;
    for (int i = 0; i < 2000; i++) begin
      logic        st, rd;
      logic [31:0] tgt;
      st  = ($urandom_range(99) < 20);
      rd  = ($urandom_range(99) < 5);
      tgt = $urandom_range(1) ? $urandom() : (32'hFFFFFFF0 | 32'($urandom_range(15)));
      applyStimulus(st, rd, tgt, 70);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
